display_mux: RTL and testbench
==============================

DISPLAY_MUX -- requirements
Module: display_mux

Interface
REQ-001 Parameter N_DIG, default 4, number of multiplexed digits (1..8); digit 0 is least significant.
REQ-002 Parameter SCAN_DIV, default 1000, clock cycles each digit is displayed (>= DEAD_CYC+2).
REQ-003 Parameter DEAD_CYC, default 2, anti-ghosting cycles at the start of each digit slot during which all digits are off.
REQ-004 Parameter SEG_ACT_LOW, default 1, segment outputs active-low when 1.
REQ-005 Parameter DIG_ACT_LOW, default 1, digit-select outputs active-low when 1.
REQ-006 clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  scanning on when 1; display dark when 0.
REQ-009 load  input  1  capture request for data_in/dp_in/blank_in.
REQ-010 data_in  input  4*N_DIG  hex nibble per digit; digit k = bits [4k+3:4k].
REQ-011 dp_in  input  N_DIG  decimal point per digit.
REQ-012 blank_in  input  N_DIG  force digit dark, including dp.
REQ-013 lz_en  input  1  leading-zero suppression enable, sampled at frame boundary with the data.
REQ-014 seg  output  7  segments {g,f,e,d,c,b,a}, registered.
REQ-015 seg_p  output  1  decimal point, registered.
REQ-016 dig_sel  output  N_DIG  one-hot digit enable, registered.
REQ-017 frame_tick  output  1  one-cycle pulse when the last digit slot ends.

Function
REQ-018 Prescaler counts 0..SCAN_DIV-1 while enable=1; at SCAN_DIV-1 it wraps to 0 and digit index advances; index wraps N_DIG-1 -> 0.
REQ-019 frame_tick SHALL be 1 exactly in the cycle after prescaler=SCAN_DIV-1 with index=N_DIG-1, otherwise 0.
REQ-020 load=1 captures inputs into a pending buffer; later loads overwrite earlier ones within a frame.
REQ-021 Active buffer updates only at frame boundary (prescaler=SCAN_DIV-1, index=N_DIG-1): takes data_in directly if load=1 that cycle, else pending; no mid-frame tearing.
REQ-022 Outputs reflect prescaler/index of previous cycle (1-cycle registered latency).
REQ-023 While prescaler < DEAD_CYC, dig_sel all inactive and seg/seg_p all off.
REQ-024 Otherwise dig_sel has only bit [index] active; seg shows active nibble for index per REQ-025.
REQ-025 Segment table (lit segments): 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc, 8 abcdefg, 9 abcdfg, A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg.
REQ-026 Digit k>=1 is suppressed when lz_en=1 and nibbles N_DIG-1..k are all 0; suppressed digit has seg off but seg_p per dp_in; digit 0 never suppressed.
REQ-027 blank_in[k]=1 forces seg and seg_p off for digit k; dig_sel still strobes.
REQ-028 "Off"/"inactive" = 1 for active-low outputs, 0 for active-high.
REQ-029 enable=0: next cycle prescaler=0, index=0, all outputs off/inactive, frame_tick=0; buffers and loads still operate; frame boundary does not occur.
REQ-030 enable rising: scanning restarts at index 0, prescaler 0, dead time applied.

Reset
REQ-031 rst_n=0 immediately (asynchronously) clears prescaler, index, pending and active buffers (data 0, dp 0, blank 0, lz 0), frame_tick=0, seg/seg_p off, dig_sel inactive.
REQ-032 Reset released mid-slot: first active slot begins at index 0, prescaler 0; no partial frame.

Verification (N_DIG=4, SCAN_DIV=4, DEAD_CYC=1, active-low)
REQ-033 Reset then enable=1, no load -> dig_sel cycles 1110,1101,1011,0111 each for 3 cycles after 1 dead cycle (1111); seg=1000000 (digit 0) for digit 0, frame_tick every 16 cycles.
REQ-034 load data_in=16'h1A3F mid-frame -> current frame unchanged; next frame digits 0..3 show F(0001110), 3(0110000), A(0001000), 1(1111001).
REQ-035 data_in=16'h0050, lz_en=1, dp_in=4'b1000 -> digits 3,2 seg=1111111 with digit 3 seg_p=0; digit 1 shows 5; digit 0 shows 0.
REQ-036 load asserted in the frame-boundary cycle with 16'h8888, pending holds 16'h1111 -> next frame shows 8 on all digits.
REQ-037 enable dropped at index 2 -> next cycle dig_sel=1111, seg=1111111; re-enable -> index 0 after 1 dead cycle.
REQ-038 rst_n pulsed low mid-slot -> outputs off same cycle, buffers zero, scanning restarts at index 0 after release.

Source files
------------

// File: rtl/display_mux.sv
// Multiplexed 7-segment display driver: per-digit scan with dead time, double-buffered
// digit data swapped only at frame boundaries, leading-zero suppression and blanking.
module display_mux #(
    parameter int N_DIG       = 4,
    parameter int SCAN_DIV    = 1000,
    parameter int DEAD_CYC    = 2,
    parameter int SEG_ACT_LOW = 1,
    parameter int DIG_ACT_LOW = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 load,
    input  logic [4*N_DIG-1:0]   data_in,
    input  logic [N_DIG-1:0]     dp_in,
    input  logic [N_DIG-1:0]     blank_in,
    input  logic                 lz_en,
    output logic [6:0]           seg,
    output logic                 seg_p,
    output logic [N_DIG-1:0]     dig_sel,
    output logic                 frame_tick
);

    localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic SEG_INV = (SEG_ACT_LOW != 0);
    localparam logic DIG_INV = (DIG_ACT_LOW != 0);
    localparam logic [6:0]       SEG_OFF = {7{SEG_INV}};
    localparam logic [N_DIG-1:0] DIG_OFF = {N_DIG{DIG_INV}};

    logic [PS_W-1:0]    prescaler;
    logic [IDX_W-1:0]   digIdx;
    logic               slotEnd;
    logic               frameEnd;

    logic [4*N_DIG-1:0] pendData, actData;
    logic [N_DIG-1:0]   pendDp, actDp;
    logic [N_DIG-1:0]   pendBlank, actBlank;
    logic               pendLz, actLz;

    logic [N_DIG-1:0]   supp;
    logic [N_DIG-1:0]   digOn;
    logic [3:0]         curNib;
    logic               curDp;
    logic               curBlank;
    logic               curSupp;
    logic [6:0]         litSeg;
    logic               litDp;
    logic               showing;

    assign slotEnd  = enable && (prescaler == PS_W'(SCAN_DIV - 1));
    assign frameEnd = slotEnd && (digIdx == IDX_W'(N_DIG - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            digIdx    <= '0;
        end else if (!enable) begin
            prescaler <= '0;
            digIdx    <= '0;
        end else if (slotEnd) begin
            prescaler <= '0;
            digIdx    <= frameEnd ? '0 : digIdx + IDX_W'(1);
        end else begin
            prescaler <= prescaler + PS_W'(1);
        end
    end

    // A load in the boundary cycle bypasses pending so the newest data wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendData  <= '0;
            pendDp    <= '0;
            pendBlank <= '0;
            pendLz    <= 1'b0;
            actData   <= '0;
            actDp     <= '0;
            actBlank  <= '0;
            actLz     <= 1'b0;
        end else begin
            if (load) begin
                pendData  <= data_in;
                pendDp    <= dp_in;
                pendBlank <= blank_in;
                pendLz    <= lz_en;
            end
            if (frameEnd) begin
                actData  <= load ? data_in  : pendData;
                actDp    <= load ? dp_in    : pendDp;
                actBlank <= load ? blank_in : pendBlank;
                actLz    <= load ? lz_en    : pendLz;
            end
        end
    end

    function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
        case (nib)
            4'h0:    hexToSeg = 7'b0111111;
            4'h1:    hexToSeg = 7'b0000110;
            4'h2:    hexToSeg = 7'b1011011;
            4'h3:    hexToSeg = 7'b1001111;
            4'h4:    hexToSeg = 7'b1100110;
            4'h5:    hexToSeg = 7'b1101101;
            4'h6:    hexToSeg = 7'b1111101;
            4'h7:    hexToSeg = 7'b0000111;
            4'h8:    hexToSeg = 7'b1111111;
            4'h9:    hexToSeg = 7'b1101111;
            4'hA:    hexToSeg = 7'b1110111;
            4'hB:    hexToSeg = 7'b1111100;
            4'hC:    hexToSeg = 7'b0111001;
            4'hD:    hexToSeg = 7'b1011110;
            4'hE:    hexToSeg = 7'b1111001;
            default: hexToSeg = 7'b1110001;
        endcase
    endfunction

    // Suppression walks down from the top digit while every nibble seen so far is zero.
    always_comb begin
        logic allZero;
        allZero  = 1'b1;
        supp     = '0;
        digOn    = '0;
        curNib   = 4'h0;
        curDp    = 1'b0;
        curBlank = 1'b0;
        curSupp  = 1'b0;
        for (int k = N_DIG - 1; k >= 0; k--) begin
            allZero = allZero && (actData[4*k +: 4] == 4'h0);
            supp[k] = actLz && allZero && (k != 0);
        end
        for (int k = 0; k < N_DIG; k++) begin
            if (digIdx == IDX_W'(k)) begin
                curNib   = actData[4*k +: 4];
                curDp    = actDp[k];
                curBlank = actBlank[k];
                curSupp  = supp[k];
                digOn[k] = 1'b1;
            end
        end
    end

    assign litSeg  = (curBlank || curSupp) ? 7'b0000000 : hexToSeg(curNib);
    assign litDp   = curDp && !curBlank;
    assign showing = enable && (int'(prescaler) >= DEAD_CYC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_OFF;
            seg_p      <= SEG_INV;
            dig_sel    <= DIG_OFF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frameEnd;
            if (showing) begin
                seg     <= litSeg ^ SEG_OFF;
                seg_p   <= litDp ^ SEG_INV;
                dig_sel <= digOn ^ DIG_OFF;
            end else begin
                seg     <= SEG_OFF;
                seg_p   <= SEG_INV;
                dig_sel <= DIG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_display_mux.sv
// Directed bench for display_mux with 4 digits, 4-cycle slots, 1 dead cycle, active-low outputs.
module tb_display_mux;

    logic        clk = 1'b0;
    logic        rstN;
    logic        enable;
    logic        load;
    logic [15:0] dataIn;
    logic [3:0]  dpIn;
    logic [3:0]  blankIn;
    logic        lzEn;
    logic [6:0]  seg;
    logic        segP;
    logic [3:0]  digSel;
    logic        frameTick;

    int nChecks = 0;
    int nErrors = 0;

    display_mux #(
        .N_DIG(4), .SCAN_DIV(4), .DEAD_CYC(1), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rstN), .enable(enable), .load(load),
        .data_in(dataIn), .dp_in(dpIn), .blank_in(blankIn), .lz_en(lzEn),
        .seg(seg), .seg_p(segP), .dig_sel(digSel), .frame_tick(frameTick)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rstN = 1'b0; enable = 1'b0; load = 1'b0; dataIn = 16'h0;
        dpIn = 4'h0; blankIn = 4'h0; lzEn = 1'b0;
        step(3);
        nChecks++; if (digSel !== 4'b1111) begin nErrors++; $display("FAIL reset_dig got %b exp 1111", digSel); end
        nChecks++; if (seg !== 7'b1111111) begin nErrors++; $display("FAIL reset_seg got %b exp 1111111", seg); end
        nChecks++; if (segP !== 1'b1) begin nErrors++; $display("FAIL reset_segp got %b exp 1", segP); end
        nChecks++; if (frameTick !== 1'b0) begin nErrors++; $display("FAIL reset_tick got %b exp 0", frameTick); end
        rstN = 1'b1; enable = 1'b1;
    endtask

    task automatic test_scan();
        int slot, pos;
        logic [3:0] expDig;
        logic [6:0] expSeg;
        logic expTick;
        for (int p = 1; p <= 32; p++) begin
            step(1);
            slot = ((p - 1) % 16) / 4;
            pos = (p - 1) % 4;
            expDig = (pos == 0) ? 4'b1111 : ~(4'b0001 << slot);
            expSeg = (pos == 0) ? 7'b1111111 : 7'b1000000;
            expTick = (p % 16 == 0);
            nChecks++; if (digSel !== expDig) begin nErrors++; $display("FAIL scan_dig p=%0d got %b exp %b", p, digSel, expDig); end
            nChecks++; if (seg !== expSeg) begin nErrors++; $display("FAIL scan_seg p=%0d got %b exp %b", p, seg, expSeg); end
            nChecks++; if (segP !== 1'b1) begin nErrors++; $display("FAIL scan_segp p=%0d got %b exp 1", p, segP); end
            nChecks++; if (frameTick !== expTick) begin nErrors++; $display("FAIL scan_tick p=%0d got %b exp %b", p, frameTick, expTick); end
        end
    endtask

    task automatic test_load_midframe();
        int slot, pos;
        logic [3:0] expDig;
        logic [6:0] expSeg;
        logic [6:0] segTab [4];
        segTab[0] = 7'b0001110; segTab[1] = 7'b0110000;
        segTab[2] = 7'b0001000; segTab[3] = 7'b1111001;
        step(5);
        load = 1'b1; dataIn = 16'h1A3F;
        step(1);
        load = 1'b0; dataIn = 16'h2222;
        for (int p = 7; p <= 16; p++) begin
            step(1);
            pos = (p - 1) % 4;
            expSeg = (pos == 0) ? 7'b1111111 : 7'b1000000;
            nChecks++; if (seg !== expSeg) begin nErrors++; $display("FAIL midframe_old_seg p=%0d got %b exp %b", p, seg, expSeg); end
        end
        for (int p = 1; p <= 16; p++) begin
            step(1);
            slot = (p - 1) / 4;
            pos = (p - 1) % 4;
            expDig = (pos == 0) ? 4'b1111 : ~(4'b0001 << slot);
            expSeg = (pos == 0) ? 7'b1111111 : segTab[slot];
            nChecks++; if (digSel !== expDig) begin nErrors++; $display("FAIL midframe_dig p=%0d got %b exp %b", p, digSel, expDig); end
            nChecks++; if (seg !== expSeg) begin nErrors++; $display("FAIL midframe_seg p=%0d got %b exp %b", p, seg, expSeg); end
        end
    endtask

    task automatic test_lz();
        int slot, pos;
        logic [6:0] expSeg;
        logic expDp;
        logic [6:0] segTab [4];
        logic dpTab [4];
        segTab[0] = 7'b1000000; segTab[1] = 7'b0010010;
        segTab[2] = 7'b1111111; segTab[3] = 7'b1111111;
        dpTab[0] = 1'b1; dpTab[1] = 1'b1; dpTab[2] = 1'b1; dpTab[3] = 1'b0;
        load = 1'b1; dataIn = 16'h0050; lzEn = 1'b1; dpIn = 4'b1000;
        step(1);
        load = 1'b0; dataIn = 16'h0; dpIn = 4'h0;
        step(15);
        for (int p = 1; p <= 16; p++) begin
            step(1);
            slot = (p - 1) / 4;
            pos = (p - 1) % 4;
            expSeg = (pos == 0) ? 7'b1111111 : segTab[slot];
            expDp = (pos == 0) ? 1'b1 : dpTab[slot];
            nChecks++; if (seg !== expSeg) begin nErrors++; $display("FAIL lz_seg p=%0d got %b exp %b", p, seg, expSeg); end
            nChecks++; if (segP !== expDp) begin nErrors++; $display("FAIL lz_segp p=%0d got %b exp %b", p, segP, expDp); end
        end
    endtask

    task automatic test_boundary_load();
        int pos;
        logic [6:0] expSeg;
        load = 1'b1; dataIn = 16'h1111; lzEn = 1'b0; dpIn = 4'h0;
        step(1);
        load = 1'b0; dataIn = 16'h0;
        step(14);
        load = 1'b1; dataIn = 16'h8888;
        step(1);
        nChecks++; if (frameTick !== 1'b1) begin nErrors++; $display("FAIL boundary_tick got %b exp 1", frameTick); end
        load = 1'b0; dataIn = 16'h0;
        for (int p = 1; p <= 16; p++) begin
            step(1);
            pos = (p - 1) % 4;
            expSeg = (pos == 0) ? 7'b1111111 : 7'b0000000;
            nChecks++; if (seg !== expSeg) begin nErrors++; $display("FAIL boundary_seg p=%0d got %b exp %b", p, seg, expSeg); end
        end
    endtask

    task automatic test_enable_drop();
        int slot, pos;
        logic [3:0] expDig;
        logic expTick;
        step(10);
        nChecks++; if (digSel !== 4'b1011) begin nErrors++; $display("FAIL drop_pre_dig got %b exp 1011", digSel); end
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            nChecks++; if (digSel !== 4'b1111) begin nErrors++; $display("FAIL drop_dig i=%0d got %b exp 1111", i, digSel); end
            nChecks++; if (seg !== 7'b1111111) begin nErrors++; $display("FAIL drop_seg i=%0d got %b exp 1111111", i, seg); end
            nChecks++; if (frameTick !== 1'b0) begin nErrors++; $display("FAIL drop_tick i=%0d got %b exp 0", i, frameTick); end
        end
        enable = 1'b1;
        for (int p = 1; p <= 16; p++) begin
            step(1);
            slot = (p - 1) / 4;
            pos = (p - 1) % 4;
            expDig = (pos == 0) ? 4'b1111 : ~(4'b0001 << slot);
            expTick = (p == 16);
            nChecks++; if (digSel !== expDig) begin nErrors++; $display("FAIL reenable_dig p=%0d got %b exp %b", p, digSel, expDig); end
            nChecks++; if (frameTick !== expTick) begin nErrors++; $display("FAIL reenable_tick p=%0d got %b exp %b", p, frameTick, expTick); end
        end
    endtask

    task automatic test_reset_mid();
        int slot, pos;
        logic [3:0] expDig;
        logic [6:0] expSeg;
        logic expTick;
        step(6);
        nChecks++; if (digSel !== 4'b1101) begin nErrors++; $display("FAIL rstmid_pre_dig got %b exp 1101", digSel); end
        #2 rstN = 1'b0;
        #1;
        nChecks++; if (digSel !== 4'b1111) begin nErrors++; $display("FAIL rstmid_dig got %b exp 1111", digSel); end
        nChecks++; if (seg !== 7'b1111111) begin nErrors++; $display("FAIL rstmid_seg got %b exp 1111111", seg); end
        nChecks++; if (segP !== 1'b1) begin nErrors++; $display("FAIL rstmid_segp got %b exp 1", segP); end
        step(2);
        rstN = 1'b1;
        for (int p = 1; p <= 32; p++) begin
            step(1);
            slot = ((p - 1) % 16) / 4;
            pos = (p - 1) % 4;
            expDig = (pos == 0) ? 4'b1111 : ~(4'b0001 << slot);
            expSeg = (pos == 0) ? 7'b1111111 : 7'b1000000;
            expTick = (p % 16 == 0);
            nChecks++; if (digSel !== expDig) begin nErrors++; $display("FAIL rstmid_scan_dig p=%0d got %b exp %b", p, digSel, expDig); end
            nChecks++; if (seg !== expSeg) begin nErrors++; $display("FAIL rstmid_scan_seg p=%0d got %b exp %b", p, seg, expSeg); end
            nChecks++; if (frameTick !== expTick) begin nErrors++; $display("FAIL rstmid_scan_tick p=%0d got %b exp %b", p, frameTick, expTick); end
        end
    endtask

    task automatic test_blank();
        int slot, pos;
        logic [3:0] expDig;
        logic [6:0] expSeg;
        logic expDp;
        load = 1'b1; dataIn = 16'h8888; dpIn = 4'b1111; blankIn = 4'b0100;
        step(1);
        load = 1'b0; dataIn = 16'h0; dpIn = 4'h0; blankIn = 4'h0;
        step(15);
        for (int p = 1; p <= 16; p++) begin
            step(1);
            slot = (p - 1) / 4;
            pos = (p - 1) % 4;
            expDig = (pos == 0) ? 4'b1111 : ~(4'b0001 << slot);
            expSeg = (pos == 0 || slot == 2) ? 7'b1111111 : 7'b0000000;
            expDp = (pos == 0 || slot == 2) ? 1'b1 : 1'b0;
            nChecks++; if (digSel !== expDig) begin nErrors++; $display("FAIL blank_dig p=%0d got %b exp %b", p, digSel, expDig); end
            nChecks++; if (seg !== expSeg) begin nErrors++; $display("FAIL blank_seg p=%0d got %b exp %b", p, seg, expSeg); end
            nChecks++; if (segP !== expDp) begin nErrors++; $display("FAIL blank_segp p=%0d got %b exp %b", p, segP, expDp); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_midframe();
        test_lz();
        test_boundary_load();
        test_enable_drop();
        test_reset_mid();
        test_blank();
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
